// File: rtl/axi4_frame_writer_if.sv
// AXI4 write-channel bundle (AW/W/B) between the frame writer (master) and the HP/ACP port (slave).
interface axi4_frame_writer_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    logic [AXI_ADDR_WIDTH-1:0]   AWADDR;
    logic                        AWVALID;
    logic                        AWREADY;
    logic [7:0]                  AWLEN;
    logic [2:0]                  AWSIZE;
    logic [1:0]                  AWBURST;
    logic [3:0]                  AWCACHE;
    logic [AXI_DATA_WIDTH-1:0]   WDATA;
    logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
    logic                        WVALID;
    logic                        WREADY;
    logic                        WLAST;
    logic                        BVALID;
    logic [1:0]                  BRESP;
    logic                        BREADY;

    modport master (
        output AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST, AWCACHE,
        output WDATA, WSTRB, WVALID, WLAST, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST, AWCACHE,
        input  WDATA, WSTRB, WVALID, WLAST, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi4_frame_writer.sv
// Packs RGB565 pixels 4-per-word into a FIFO and writes 64-beat INCR bursts to a double frame buffer;
// no upstream backpressure (full FIFO drops words, sets overflow). AXI4_WRITER_BRESP_CHECK_EN enables bresp_err.
module axi4_frame_writer #(
    parameter int                      AXI_ADDR_WIDTH   = 32,
    parameter int                      AXI_DATA_WIDTH   = 64,
    parameter int                      FIFO_DEPTH       = 256,
    parameter int                      BURSTS_PER_FRAME = 300,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR_0    = 32'h0100_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR_1    = 32'h0110_0000
) (
    input  logic        clk_100Mhz,
    input  logic        rst,
    input  logic [15:0] pixel_in,
    input  logic        pixel_valid,
    input  logic        frame_start,
    axi4_frame_writer_if.master axi,
    output logic        buf_select,
    output logic        frame_done,
    output logic        overflow,
    output logic        sync_err,
    output logic        bresp_err,
    output logic [2:0]  state
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int BCW = $clog2(BURSTS_PER_FRAME + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t cur, nxt;

    logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AXI_DATA_WIDTH-1:0] word;
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             count, owed, stale, stale_nxt;
    logic [1:0]                lane, lane_eff;
    logic [47:0]               pack;
    logic [5:0]                beat;
    logic [BCW-1:0]            burst_cnt;
    logic [AXI_ADDR_WIDTH-1:0] offset, awaddr_q, target;
    logic                      fifo_full, push_word, push, pop, drop_pop, sync_hit, pend_reset;

    assign lane_eff  = frame_start ? 2'd0 : lane;
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign push_word = pixel_valid && (lane_eff == 2'd3);
    assign push      = push_word && !fifo_full;
    assign drop_pop  = (cur == S_DROP);
    assign pop       = ((cur == S_W) && axi.WREADY) || drop_pop;
    assign word      = AXI_DATA_WIDTH'({pack, pixel_in});
    assign target    = buf_select ? BASE_ADDR_1 : BASE_ADDR_0;

    // Words already committed to an address phase are not stale: they belong to the burst in flight.
    always_comb begin
        owed = '0;
        if (cur == S_AW)
            owed = CW'(64);
        else if (cur == S_W)
            owed = CW'(64) - CW'(beat);
    end

    always_comb begin
        stale_nxt = stale;
        if (drop_pop)
            stale_nxt = stale - CW'(1);
        if (frame_start)
            stale_nxt = count - owed - CW'(drop_pop);
    end

    assign sync_hit = frame_start && ((stale_nxt != '0) || (lane != 2'd0) || (burst_cnt != '0));

    always_ff @(posedge clk_100Mhz) begin
        if (rst)
            cur <= S_IDLE;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt         = cur;
        axi.AWVALID = 1'b0;
        axi.WVALID  = 1'b0;
        axi.WLAST   = 1'b0;
        axi.BREADY  = 1'b0;
        axi.WDATA   = '0;
        axi.AWADDR  = awaddr_q;
        axi.AWLEN   = 8'd63;
        axi.AWSIZE  = 3'b011;
        axi.AWBURST = 2'b01;
        axi.AWCACHE = 4'b1111;
        axi.WSTRB   = '1;
        state       = cur;
        case (cur)
            // A frame_start cycle holds IDLE so the stale count is settled before any burst is launched.
            S_IDLE: begin
                if (!frame_start) begin
                    if (stale != '0)
                        nxt = S_DROP;
                    else if (count >= CW'(64))
                        nxt = S_AW;
                end
            end
            S_AW: begin
                axi.AWVALID = 1'b1;
                if (axi.AWREADY)
                    nxt = S_W;
            end
            S_W: begin
                axi.WVALID = 1'b1;
                axi.WDATA  = mem[rd_ptr];
                axi.WLAST  = (beat == 6'd63);
                if (axi.WREADY && beat == 6'd63)
                    nxt = S_B;
            end
            S_B: begin
                axi.BREADY = 1'b1;
                if (axi.BVALID)
                    nxt = S_IDLE;
            end
            S_DROP: begin
                if (stale_nxt == '0)
                    nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz) begin
        if (push)
            mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lane       <= 2'd0;
            pack       <= '0;
            beat       <= '0;
            offset     <= '0;
            awaddr_q   <= '0;
            burst_cnt  <= '0;
            stale      <= '0;
            pend_reset <= 1'b0;
            buf_select <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pixel_valid) begin
                pack <= {pack[31:0], pixel_in};
                lane <= lane_eff + 2'd1;
            end else begin
                lane <= lane_eff;
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            stale <= stale_nxt;
            if (push_word && fifo_full)
                overflow <= 1'b1;
            case (cur)
                S_IDLE: begin
                    if (pend_reset) begin
                        offset     <= '0;
                        burst_cnt  <= '0;
                        pend_reset <= 1'b0;
                    end
                    if (nxt == S_AW) begin
                        awaddr_q <= target + (pend_reset ? '0 : offset);
                        beat     <= '0;
                    end
                end
                S_W: begin
                    if (axi.WREADY)
                        beat <= beat + 6'd1;
                end
                S_B: begin
                    if (axi.BVALID) begin
                        if (burst_cnt == BCW'(BURSTS_PER_FRAME - 1)) begin
                            burst_cnt  <= '0;
                            offset     <= '0;
                            buf_select <= ~buf_select;
                            frame_done <= 1'b1;
                        end else begin
                            burst_cnt <= burst_cnt + BCW'(1);
                            offset    <= offset + AXI_ADDR_WIDTH'(512);
                        end
                    end
                end
                default: ;
            endcase
            if (sync_hit) begin
                sync_err   <= 1'b1;
                pend_reset <= 1'b1;
            end
        end
    end

`ifdef AXI4_WRITER_BRESP_CHECK_EN
    always_ff @(posedge clk_100Mhz) begin
        if (rst)
            bresp_err <= 1'b0;
        else if (cur == S_B && axi.BVALID && axi.BRESP != 2'b00)
            bresp_err <= 1'b1;
    end
`else
    logic unused_bresp;
    assign unused_bresp = ^axi.BRESP;
    assign bresp_err    = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_frame_writer.sv
// Directed bench for axi4_frame_writer with a word-queue scoreboard checked every cycle on the falling edge.
module tb_axi4_frame_writer;
    localparam int          BPF   = 4;
    localparam int          DEPTH = 256;
    localparam logic [31:0] B0    = 32'h0100_0000;
    localparam logic [31:0] B1    = 32'h0110_0000;

    logic        clk_100Mhz = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        buf_select, frame_done, overflow, sync_err, bresp_err;
    logic [2:0]  state;

    axi4_frame_writer_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) axi();

    axi4_frame_writer #(.FIFO_DEPTH(DEPTH), .BURSTS_PER_FRAME(BPF)) dut (
        .clk_100Mhz  (clk_100Mhz),
        .rst         (rst),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .axi         (axi.master),
        .buf_select  (buf_select),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .sync_err    (sync_err),
        .bresp_err   (bresp_err),
        .state       (state)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave behaviour knobs, written only by the main sequence.
    int       aw_delay = 0;
    bit       w_rand = 0;
    bit       aw_block = 0;
    logic [1:0] bresp_drive = 2'b00;

    // Scoreboard: words the DUT must write, in order, plus frame bookkeeping.
    logic [63:0] q[$];
    logic [15:0] pix_q[$];
    int  burst_idx_m, beats_left_m, owed_m, stale_m, qs0;
    bit  buf_m, ovf_m, sync_m, pend_m, fd_m, fd_next, active_m, await_b_m;
    logic [63:0] word_m;
    logic [31:0] exp_addr;

    // Monitor logs.
    int  n_aw, n_w, n_wlast, n_fd, n_drop;
    logic [31:0] aw_log[$];
    logic [63:0] first_w;
    bit  got_w, prev_aw_pend;
    logic [31:0] prev_addr;

    always @(negedge clk_100Mhz) begin
        if (rst) begin
            q.delete(); pix_q.delete();
            burst_idx_m = 0; beats_left_m = 0;
            buf_m = 0; ovf_m = 0; sync_m = 0; pend_m = 0; fd_m = 0;
            active_m = 0; await_b_m = 0; prev_aw_pend = 0;
        end else begin
            chk("frame_done", frame_done, fd_m);
            chk("buf_select", buf_select, buf_m);
            chk("overflow", overflow, ovf_m);
            chk("sync_err", sync_err, sync_m);
            chk("bresp_err", bresp_err, 0);
            if (prev_aw_pend) begin
                chk("awvalid_hold", axi.AWVALID, 1);
                chk("awaddr_hold", axi.AWADDR, prev_addr);
            end
            if (axi.AWVALID) begin
                exp_addr = (buf_m ? B1 : B0) + 32'(burst_idx_m * 512);
                chk("aw_state", state, 1);
                chk("awaddr", axi.AWADDR, exp_addr);
                chk("aw_consts", {axi.AWLEN, axi.AWSIZE, axi.AWBURST, axi.AWCACHE},
                    {8'd63, 3'b011, 2'b01, 4'b1111});
                chk("aw_exclusive", axi.WVALID | axi.BREADY, 0);
            end
            if (axi.WVALID) begin
                chk("w_state", state, 2);
                chk("wstrb", axi.WSTRB, 8'hFF);
                chk("wlast", axi.WLAST, beats_left_m == 1);
                if (q.size() == 0) chk("w_underflow", 1, 0);
                else chk("wdata", axi.WDATA, q[0]);
            end
            if (axi.BREADY) begin
                chk("b_state", state, 3);
                chk("b_exclusive", axi.AWVALID | axi.WVALID, 0);
            end
            if (state == 3'd4) begin
                n_drop++;
                chk("drop_no_axi", axi.AWVALID | axi.WVALID, 0);
            end

            // Logs for the directed literal checks.
            if (axi.AWVALID && axi.AWREADY) begin n_aw++; aw_log.push_back(axi.AWADDR); end
            if (axi.WVALID && axi.WREADY) begin
                n_w++;
                if (axi.WLAST) n_wlast++;
                if (!got_w) begin first_w = axi.WDATA; got_w = 1; end
            end
            if (frame_done) n_fd++;
            prev_aw_pend = axi.AWVALID && !axi.AWREADY;
            prev_addr    = axi.AWADDR;

            // Advance the model through the coming clock edge.
            fd_next = 0;
            qs0 = q.size();
            if (axi.AWVALID && !active_m && !await_b_m) begin
                active_m = 1; beats_left_m = 64;
            end
            if (frame_start) begin
                owed_m  = active_m ? beats_left_m : 0;
                stale_m = q.size() - owed_m;
                if (stale_m != 0 || pix_q.size() != 0 || burst_idx_m != 0) begin
                    sync_m = 1;
                    while (q.size() > owed_m) void'(q.pop_back());
                    if (active_m || await_b_m) pend_m = 1;
                    else burst_idx_m = 0;
                end
                pix_q.delete();
            end
            if (axi.WVALID && axi.WREADY) begin
                if (q.size() != 0) void'(q.pop_front());
                beats_left_m--;
                if (beats_left_m == 0) begin active_m = 0; await_b_m = 1; end
            end
            if (axi.BVALID && axi.BREADY) begin
                await_b_m = 0;
                burst_idx_m++;
                if (burst_idx_m == BPF) begin burst_idx_m = 0; buf_m = !buf_m; fd_next = 1; end
                if (pend_m) begin burst_idx_m = 0; pend_m = 0; end
            end
            if (pixel_valid) begin
                pix_q.push_back(pixel_in);
                if (pix_q.size() == 4) begin
                    word_m = {pix_q[0], pix_q[1], pix_q[2], pix_q[3]};
                    if (qs0 == DEPTH) ovf_m = 1;
                    else q.push_back(word_m);
                    pix_q.delete();
                end
            end
            fd_m = fd_next;
        end
    end

    // AXI slave: AWREADY after a programmable wait, optional random WREADY, one B per WLAST.
    int  aw_wait = 0;
    bit  d_wl, d_b;
    initial begin
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 2'b00;
        forever begin
            @(negedge clk_100Mhz);
            d_wl = axi.WVALID && axi.WREADY && axi.WLAST;
            d_b  = axi.BVALID && axi.BREADY;
            if (axi.AWVALID && !axi.AWREADY) aw_wait++;
            else aw_wait = 0;
            @(posedge clk_100Mhz);
            #1;
            if (rst || d_b) axi.BVALID = 0;
            if (d_wl && !rst) begin axi.BVALID = 1; axi.BRESP = bresp_drive; end
            axi.AWREADY = !aw_block && axi.AWVALID && (aw_wait >= aw_delay);
            axi.WREADY  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input int n, input logic [15:0] start, input bit fs);
        for (int i = 0; i < n; i++) begin
            pixel_in    = start + 16'(i);
            pixel_valid = 1'b1;
            frame_start = fs && (i == 0);
            @(posedge clk_100Mhz);
            #1;
        end
        pixel_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int budget);
        int k = 0;
        while (n_fd < target && k < budget) begin
            @(posedge clk_100Mhz);
            #1;
            k++;
        end
        repeat (5) begin @(posedge clk_100Mhz); #1; end
        chk("frame_done_count", n_fd, target);
    endtask

    task automatic clear_logs();
        aw_log.delete();
        got_w = 0; n_w = 0; n_wlast = 0; n_aw = 0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valids"}, {axi.AWVALID, axi.WVALID, axi.BREADY, axi.WLAST}, 4'b0000);
        chk({tag, "_awaddr"}, axi.AWADDR, 0);
        chk({tag, "_wdata"}, axi.WDATA, 0);
        chk({tag, "_flags"}, {buf_select, frame_done, overflow, sync_err, bresp_err}, 5'b00000);
        chk({tag, "_state"}, state, 0);
    endtask

    initial begin
        n_fd = 0; n_drop = 0;
        clear_logs();
        repeat (3) @(posedge clk_100Mhz);
        #1;
        rst = 1'b0;
        reset_checks("reset");

        // Frame 1: everything ready, pixels 1,2,3,...
        send(1024, 16'h0001, 1'b1);
        wait_fd(1, 2000);
        chk("f1_aw_count", n_aw, 4);
        chk("f1_first_awaddr", aw_log[0], 32'h0100_0000);
        chk("f1_last_awaddr", aw_log[3], 32'h0100_0600);
        chk("f1_first_wdata", first_w, 64'h0001_0002_0003_0004);
        chk("f1_w_beats", n_w, 256);
        chk("f1_wlast_count", n_wlast, 4);
        chk("f1_buf_select", buf_select, 1);

        // Frame 2: slow AWREADY, random WREADY, error responses ignored.
        clear_logs();
        aw_delay = 7; w_rand = 1; bresp_drive = 2'b10;
        send(1024, 16'h1000, 1'b1);
        wait_fd(2, 6000);
        chk("f2_first_awaddr", aw_log[0], 32'h0110_0000);
        chk("f2_last_awaddr", aw_log[3], 32'h0110_0600);
        chk("f2_w_beats", n_w, 256);
        chk("f2_wlast_count", n_wlast, 4);
        chk("f2_buf_select", buf_select, 0);
        chk("f2_bresp_err", bresp_err, 0);

        // Frame restarted after 1000 pixels: 58 stale words dropped, offset restarts.
        aw_delay = 0; w_rand = 0; bresp_drive = 2'b00;
        send(1000, 16'h2000, 1'b1);
        clear_logs();
        n_drop = 0;
        send(1024, 16'h8000, 1'b1);
        wait_fd(3, 3000);
        chk("sync_err_set", sync_err, 1);
        chk("drop_cycles", n_drop, 58);
        chk("resync_first_awaddr", aw_log[0], 32'h0100_0000);
        chk("resync_first_wdata", first_w, 64'h8000_8001_8002_8003);
        chk("resync_aw_count", n_aw, 4);
        chk("resync_buf_select", buf_select, 1);

        // Overflow with the address channel stalled.
        rst = 1'b1;
        repeat (2) @(posedge clk_100Mhz);
        #1;
        rst = 1'b0;
        reset_checks("reset2");
        clear_logs();
        aw_block = 1;
        send(4 * (DEPTH + 1), 16'h4000, 1'b1);
        repeat (10) begin @(posedge clk_100Mhz); #1; end
        chk("ovf_flag", overflow, 1);
        chk("ovf_state", state, 1);
        chk("ovf_awvalid", axi.AWVALID, 1);
        chk("ovf_no_w", n_w, 0);

        // Reset in the middle of a stalled address phase.
        rst = 1'b1;
        repeat (2) @(posedge clk_100Mhz);
        #1;
        rst = 1'b0;
        reset_checks("reset3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
